// File: rtl/forward_ctrl.sv
// Operand-forwarding select and load-use stall control for a 5-stage pipeline.
// Tracks producers in EX and MEM and registers per-operand mux selects for the EX stage.
module forward_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             freeze,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wd,
  input  logic             id_is_load,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             ex_valid_reg;
  logic             ex_wr_reg;
  logic [REG_W-1:0] ex_wd_reg;
  logic             ex_load_reg;
  logic             mem_valid_reg;
  logic             mem_wr_reg;
  logic [REG_W-1:0] mem_wd_reg;
  logic [1:0][1:0]  sel_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic [1:0][REG_W-1:0] src;
  logic [1:0]            use_src;
  logic [1:0]            hit_ex;
  logic [1:0]            hit_mem;
  logic [1:0][1:0]       sel_next;
  logic                  ex_fwd_ok;
  logic                  mem_fwd_ok;
  logic                  bubble;

  assign src     = {id_rt, id_rs};
  assign use_src = {id_use_rt, id_use_rs};

  // Register 0 is hard-wired zero, so a producer writing it can never be a source.
  assign ex_fwd_ok  = ex_valid_reg & ex_wr_reg & (ex_wd_reg != '0);
  assign mem_fwd_ok = mem_valid_reg & mem_wr_reg & (mem_wd_reg != '0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign hit_ex[gi]  = use_src[gi] & ex_fwd_ok & (ex_wd_reg == src[gi]);
      assign hit_mem[gi] = use_src[gi] & mem_fwd_ok & (mem_wd_reg == src[gi]);
      // A load in EX has no result yet; that case is covered by the stall.
      assign sel_next[gi] = bubble                       ? 2'b00 :
                            (hit_ex[gi] & ~ex_load_reg)  ? 2'b01 :
                            hit_mem[gi]                  ? 2'b10 : 2'b00;
    end
  endgenerate

  assign stall  = ~flush & id_valid & ex_load_reg & (|hit_ex);
  assign bubble = stall | flush | ~id_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ex_valid_reg  <= 1'b0;
      ex_wr_reg     <= 1'b0;
      ex_wd_reg     <= '0;
      ex_load_reg   <= 1'b0;
      mem_valid_reg <= 1'b0;
      mem_wr_reg    <= 1'b0;
      mem_wd_reg    <= '0;
      sel_reg       <= '0;
      stall_cnt_reg <= '0;
    end else if (!freeze) begin
      mem_valid_reg <= ex_valid_reg;
      mem_wr_reg    <= ex_wr_reg;
      mem_wd_reg    <= ex_wd_reg;
      ex_valid_reg  <= ~bubble;
      ex_wr_reg     <= ~bubble & id_wr_en;
      ex_wd_reg     <= bubble ? '0 : id_wd;
      ex_load_reg   <= ~bubble & id_is_load;
      sel_reg       <= sel_next;
      if (stall && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end
  end

  assign fwd_a_sel = sel_reg[0];
  assign fwd_b_sel = sel_reg[1];
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed vector table plus randomized traffic checked against a slot-history model.
module tb_forward_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             resetn, freeze, flush, id_valid;
  logic [REG_W-1:0] id_rs, id_rt, id_wd;
  logic             id_use_rs, id_use_rt, id_wr_en, id_is_load;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  forward_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wr_en(id_wr_en), .id_wd(id_wd), .id_is_load(id_is_load),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       resetn, freeze, flush, v;
    bit [4:0] rs, rt;
    bit       ur, ut, wr;
    bit [4:0] wd;
    bit       ld;
    bit       e_stall;
    bit [1:0] e_a, e_b;
    bit [2:0] e_cnt;
  } vec_t;

  typedef struct {
    bit       valid, wr, load;
    bit [4:0] wd;
  } slot_t;

  // Reference model: producer history, index 0 = newest (EX), 1 = MEM.
  slot_t    m_hist [2];
  bit [1:0] m_a, m_b;
  int       m_cnt;

  function automatic vec_t mk(bit r, bit f, bit fl, bit v, bit [4:0] rs, bit [4:0] rt,
                              bit ur, bit ut, bit wr, bit [4:0] wd, bit ld,
                              bit es, bit [1:0] ea, bit [1:0] eb, bit [2:0] ec);
    vec_t x;
    x.resetn = r; x.freeze = f; x.flush = fl; x.v = v; x.rs = rs; x.rt = rt;
    x.ur = ur; x.ut = ut; x.wr = wr; x.wd = wd; x.ld = ld;
    x.e_stall = es; x.e_a = ea; x.e_b = eb; x.e_cnt = ec;
    return x;
  endfunction

  function automatic bit produces(slot_t p, bit [4:0] r);
    return p.valid && p.wr && (p.wd != 0) && (p.wd == r);
  endfunction

  function automatic bit model_stall(vec_t x);
    if (x.flush || !x.v || !m_hist[0].load) return 0;
    return (x.ur && produces(m_hist[0], x.rs)) || (x.ut && produces(m_hist[0], x.rt));
  endfunction

  function automatic bit [1:0] model_sel(bit used, bit [4:0] r);
    if (!used) return 2'd0;
    if (produces(m_hist[0], r) && !m_hist[0].load) return 2'd1;
    if (produces(m_hist[1], r)) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_clock(vec_t x);
    bit    bub;
    slot_t s;
    if (!x.resetn) begin
      m_hist[0] = '{default: 0};
      m_hist[1] = '{default: 0};
      m_a = 0; m_b = 0; m_cnt = 0;
    end else if (!x.freeze) begin
      bub = model_stall(x) || x.flush || !x.v;
      m_a = bub ? 2'd0 : model_sel(x.ur, x.rs);
      m_b = bub ? 2'd0 : model_sel(x.ut, x.rt);
      if (model_stall(x) && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
      s = '{default: 0};
      if (!bub) begin
        s.valid = 1; s.wr = x.wr; s.wd = x.wd; s.load = x.ld;
      end
      m_hist[1] = m_hist[0];
      m_hist[0] = s;
    end
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t x, string tag);
    resetn = x.resetn; freeze = x.freeze; flush = x.flush; id_valid = x.v;
    id_rs = x.rs; id_rt = x.rt; id_use_rs = x.ur; id_use_rt = x.ut;
    id_wr_en = x.wr; id_wd = x.wd; id_is_load = x.ld;
    #2;
    chk({tag, " stall"}, {7'd0, stall}, {7'd0, x.e_stall});
    @(posedge clk);
    #1;
    chk({tag, " fwd_a_sel"}, {6'd0, fwd_a_sel}, {6'd0, x.e_a});
    chk({tag, " fwd_b_sel"}, {6'd0, fwd_b_sel}, {6'd0, x.e_b});
    chk({tag, " stall_cnt"}, {5'd0, stall_cnt}, {5'd0, x.e_cnt});
    $display("%s: rst_n=%0b frz=%0b fl=%0b v=%0b rs=%0d rt=%0d wd=%0d ld=%0b -> stall=%0b a=%0d b=%0d cnt=%0d",
             tag, x.resetn, x.freeze, x.flush, x.v, x.rs, x.rt, x.wd, x.ld,
             stall, fwd_a_sel, fwd_b_sel, stall_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    vec_t x;

    resetn = 0; freeze = 0; flush = 0; id_valid = 0;
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_wr_en = 0; id_wd = 0; id_is_load = 0;
    repeat (2) @(posedge clk);
    #1;

    //               r f fl v  rs rt ur ut wr wd ld  st a b cnt
    tbl.push_back(mk(0,0,0,0,  0, 0, 0, 0, 0, 0, 0,  0,0,0,0)); // reset state
    tbl.push_back(mk(1,0,0,1,  1, 2, 1, 1, 1, 3, 0,  0,0,0,0)); // add $3
    tbl.push_back(mk(1,0,0,1,  3, 4, 1, 1, 1, 6, 0,  0,1,0,0)); // sub rs=3 -> EX fwd
    tbl.push_back(mk(1,0,0,1,  1, 2, 1, 1, 1, 3, 0,  0,0,0,0)); // add $3
    tbl.push_back(mk(1,0,0,0,  0, 0, 0, 0, 0, 0, 0,  0,0,0,0)); // nop
    tbl.push_back(mk(1,0,0,1,  7, 3, 1, 1, 1, 8, 0,  0,0,2,0)); // and rt=3 -> MEM fwd
    tbl.push_back(mk(1,0,0,1,  1, 2, 1, 1, 1, 3, 0,  0,0,0,0)); // add $3
    tbl.push_back(mk(1,0,0,1,  1, 2, 1, 1, 1, 3, 0,  0,0,0,0)); // add $3 again
    tbl.push_back(mk(1,0,0,1,  3, 0, 1, 0, 1, 9, 0,  0,1,0,0)); // or rs=3 -> newest wins
    tbl.push_back(mk(1,0,0,1,  1, 0, 1, 0, 1, 5, 1,  0,0,0,0)); // lw $5
    tbl.push_back(mk(1,0,0,1,  5, 2, 1, 1, 1,10, 0,  1,0,0,1)); // addu rs=5 stalls
    tbl.push_back(mk(1,0,0,1,  5, 2, 1, 1, 1,10, 0,  0,2,0,1)); // addu retried -> MEM fwd
    tbl.push_back(mk(1,0,0,1,  1, 0, 1, 0, 1, 5, 1,  0,0,0,1)); // lw $5
    tbl.push_back(mk(1,0,1,1,  5, 2, 1, 1, 1,10, 0,  0,0,0,1)); // dependent but flushed
    tbl.push_back(mk(1,0,0,1,  1, 2, 1, 1, 1, 0, 0,  0,0,0,1)); // producer wd=0
    tbl.push_back(mk(1,0,0,1,  0, 0, 1, 1, 1,11, 0,  0,0,0,1)); // consumer rs=rt=0
    tbl.push_back(mk(1,0,0,1,  1, 0, 1, 0, 1, 0, 1,  0,0,0,1)); // load to $0
    tbl.push_back(mk(1,0,0,1,  0, 0, 1, 1, 1,12, 0,  0,0,0,1)); // no stall on $0
    tbl.push_back(mk(1,0,0,1,  1, 2, 1, 1, 1, 3, 0,  0,0,0,1)); // add $3
    tbl.push_back(mk(1,1,0,1,  3, 4, 1, 1, 1, 6, 0,  0,0,0,1)); // freeze x3
    tbl.push_back(mk(1,1,0,1,  3, 4, 1, 1, 1, 6, 0,  0,0,0,1));
    tbl.push_back(mk(1,1,0,1,  3, 4, 1, 1, 1, 6, 0,  0,0,0,1));
    tbl.push_back(mk(1,0,0,1,  3, 4, 1, 1, 1, 6, 0,  0,1,0,1)); // resumes -> EX fwd
    tbl.push_back(mk(1,0,0,1,  1, 0, 1, 0, 1, 5, 1,  0,0,0,1)); // lw $5
    tbl.push_back(mk(1,1,0,1,  5, 2, 1, 1, 1,10, 0,  1,0,0,1)); // stall while frozen: cnt held
    tbl.push_back(mk(1,0,0,1,  5, 2, 1, 1, 1,10, 0,  1,0,0,2)); // stall advances
    tbl.push_back(mk(1,0,0,1,  5, 2, 1, 1, 1,10, 0,  0,2,0,2));
    tbl.push_back(mk(1,0,0,1,  1, 0, 1, 0, 1, 5, 1,  0,0,0,2)); // lw $5
    tbl.push_back(mk(0,0,0,1,  5, 2, 1, 1, 1,10, 0,  1,0,0,0)); // reset during stall
    tbl.push_back(mk(1,0,0,1,  5, 2, 1, 1, 1,10, 0,  0,0,0,0)); // hazard gone
    tbl.push_back(mk(1,0,0,1,  1, 2, 1, 1, 1, 3, 0,  0,0,0,0)); // add $3
    tbl.push_back(mk(1,0,0,1,  3, 4, 1, 1, 1, 6, 0,  0,1,0,0)); // sub -> EX fwd
    tbl.push_back(mk(0,1,1,1,  3, 4, 1, 1, 1, 6, 0,  0,0,0,0)); // reset beats freeze/flush

    foreach (tbl[i]) apply(tbl[i], $sformatf("row %0d", i));

    m_hist[0] = '{default: 0};
    m_hist[1] = '{default: 0};
    m_a = 0; m_b = 0; m_cnt = 0;
    for (int n = 0; n < 600; n++) begin
      x.resetn = (n == 0) ? 1'b0 : ($urandom_range(0, 99) >= 2);
      x.freeze = ($urandom_range(0, 99) < 12);
      x.flush  = ($urandom_range(0, 99) < 10);
      x.v      = ($urandom_range(0, 99) < 85);
      x.rs     = 5'($urandom_range(0, 3));
      x.rt     = 5'($urandom_range(0, 3));
      x.ur     = 1'($urandom_range(0, 1));
      x.ut     = 1'($urandom_range(0, 1));
      x.wr     = ($urandom_range(0, 99) < 80);
      x.wd     = 5'($urandom_range(0, 3));
      x.ld     = ($urandom_range(0, 99) < 35);
      x.e_stall = model_stall(x);
      model_clock(x);
      x.e_a   = m_a;
      x.e_b   = m_b;
      x.e_cnt = 3'(m_cnt);
      apply(x, $sformatf("rnd %0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 Parameter REG_W, default 5, width of a register index.
REQ-002 Parameter CNT_W, default 16, width of the stall-event counter.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port resetn  input  1  reset, synchronous and active-low: sampled on the rising edge of clk; when 0, all state is cleared.
REQ-005 Port freeze  input  1  global pipeline hold (memory wait); 1 = hold all state.
REQ-006 Port flush  input  1  branch/jump squash of the instruction now in ID.
REQ-007 Port id_valid  input  1  ID holds a real instruction.
REQ-008 Port id_rs, id_rt  input  REG_W each  ID source register indices.
REQ-009 Port id_use_rs, id_use_rt  input  1 each  ID instruction reads rs / rt.
REQ-010 Port id_wr_en  input  1  ID instruction writes a register.
REQ-011 Port id_wd  input  REG_W  ID destination register index.
REQ-012 Port id_is_load  input  1  ID instruction is a load.
REQ-013 Port fwd_a_sel, fwd_b_sel  output  2 each  registered select for the EX operand 3-input muxes: 00 = register file, 01 = EX/MEM ALU result, 10 = MEM/WB result; 11 is never driven.
REQ-014 Port stall  output  1  combinational load-use stall request to PC and IF/ID.
REQ-015 Port stall_cnt  output  CNT_W  count of cycles in which a load-use bubble was inserted.

Function
REQ-016 Internal tracking regs: EX slot {ex_valid, ex_wr, ex_wd, ex_load}, MEM slot {mem_valid, mem_wr, mem_wd}.
REQ-017 "Advance" = resetn=1 and freeze=0; with no advance, every register holds its value (stall still evaluated combinationally).
REQ-018 stall = id_valid & ex_valid & ex_load & ex_wr & (ex_wd != 0) & ((id_use_rs & id_rs==ex_wd) | (id_use_rt & id_rt==ex_wd)).
REQ-019 stall SHALL be forced 0 when flush=1.
REQ-020 On advance: MEM slot <= EX slot; EX slot <= ID fields, except a bubble (all fields 0) when stall=1, flush=1, or id_valid=0.
REQ-021 Per-operand select computed in ID, registered into fwd_*_sel on advance, so it is valid in the cycle the instruction occupies EX (latency 1).
REQ-022 Select = 01 if operand used, EX slot valid, ex_wr, ex_wd != 0, ex_wd == source, ex_load=0.
REQ-023 Else select = 10 if operand used, MEM slot valid, mem_wr, mem_wd != 0, mem_wd == source.
REQ-024 Else 00; EX-slot match has priority over MEM-slot match (newest producer wins).
REQ-025 When a bubble is registered into EX, both selects SHALL be registered as 00.
REQ-026 Register index 0 is never a forwarding source or stall cause.
REQ-027 stall_cnt increments by 1 on every advance with stall=1; saturates at all ones (no wrap).
REQ-028 flush and stall together: flush wins; bubble inserted, stall_cnt not incremented.

Reset
REQ-029 When resetn=0 at a rising edge: both slots cleared, fwd_a_sel=00, fwd_b_sel=00, stall_cnt=0; stall evaluates 0 thereafter until a load enters EX.
REQ-030 Reset asserted mid-stall clears the pending hazard; the first instruction after reset sees selects 00.
REQ-031 Reset has priority over freeze and flush.

Verification
REQ-032 add $3 (wd=3, wr=1) then next cycle sub using rs=3 -> in sub's EX cycle fwd_a_sel=01, fwd_b_sel=00, stall=0.
REQ-033 add $3, nop, and using rt=3 -> and's EX cycle fwd_b_sel=10; add $3, add $3, or rs=3 -> fwd_a_sel=01 (priority).
REQ-034 lw $5 then addu rs=5 -> stall=1 for exactly one cycle, stall_cnt 0->1, addu EX cycle fwd_a_sel=10.
REQ-035 lw $5 + dependent instr with flush=1 -> stall=0, bubble enters EX, stall_cnt unchanged; wd=0 producer + rs=0 consumer -> selects 00.
REQ-036 freeze=1 for 3 cycles during a forwarding sequence -> selects, slots, stall_cnt held; sequence resumes unchanged after freeze=0.
REQ-037 resetn=0 for one edge while stall=1 -> next cycle selects 00, stall_cnt=0, stall=0.
